// File: rtl/e203_rst_req_seq.sv
// Reset-request sequencer: merges POR, watchdog, debug and software requests into one sys_rst_n pulse.
// Optional sticky cause register guarded by E203_RST_CAUSE_EN.
module e203_rst_req_seq #(
  parameter int RST_PULSE_CYCLES = 16,
  parameter int RELEASE_GAP      = 4,
  parameter int CNT_W            = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wdog_rst_req,
  input  logic       dbg_rst_req,
  input  logic       sw_rst_req,
  input  logic       rst_hold_i,
  input  logic       rst_cause_clr,
  output logic       sys_rst_n,
  output logic       rst_busy,
  output logic [3:0] rst_cause
);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_ASSERT = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;
  localparam logic [1:0] S_SETTLE = 2'd3;

  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(RELEASE_GAP - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             pend;
  logic             pend_nxt;
  logic             req;
  logic             cnt_zero;

  assign req      = wdog_rst_req | dbg_rst_req | sw_rst_req;
  assign cnt_zero = (cnt == '0);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pend_nxt  = pend;
    unique case (1'b1)
      state == S_RUN: begin
        if (req) begin
          state_nxt = S_ASSERT;
          cnt_nxt   = PULSE_LD;
        end
      end
      state == S_ASSERT: begin
        if (!cnt_zero) begin
          cnt_nxt = cnt - 1'b1;
        end else if (rst_hold_i) begin
          state_nxt = S_HOLD;
        end else begin
          state_nxt = S_SETTLE;
          cnt_nxt   = GAP_LD;
        end
      end
      state == S_HOLD: begin
        if (!rst_hold_i) begin
          state_nxt = S_SETTLE;
          cnt_nxt   = GAP_LD;
        end
      end
      default: begin
        // A request on the last settle cycle counts as pending too
        if (!cnt_zero) begin
          cnt_nxt  = cnt - 1'b1;
          pend_nxt = pend | req;
        end else if (pend | req) begin
          state_nxt = S_ASSERT;
          cnt_nxt   = PULSE_LD;
          pend_nxt  = 1'b0;
        end else begin
          state_nxt = S_RUN;
          pend_nxt  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_ASSERT;
      cnt       <= PULSE_LD;
      pend      <= 1'b0;
      sys_rst_n <= 1'b0;
      rst_busy  <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pend      <= pend_nxt;
      sys_rst_n <= (state_nxt == S_RUN) || (state_nxt == S_SETTLE);
      rst_busy  <= (state_nxt != S_RUN);
    end
  end

`ifdef E203_RST_CAUSE_EN
  logic [3:0] cause;
  logic [3:0] req_bits;

  assign req_bits = {sw_rst_req, dbg_rst_req, wdog_rst_req, 1'b0};

  // Request bits win over a same-cycle clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cause <= 4'b0001;
    end else if (state == S_RUN) begin
      if (req) begin
        cause <= req_bits;
      end else if (rst_cause_clr) begin
        cause <= 4'b0000;
      end
    end else begin
      cause <= cause | req_bits;
    end
  end

  assign rst_cause = cause;
`else
  logic unused_cause_clr;

  assign unused_cause_clr = rst_cause_clr;
  assign rst_cause        = 4'b0000;
`endif

endmodule
